// File: rtl/shift_reg_pkg.sv
// rtl/shift_reg_pkg.sv - opcodes, burst FSM states and direction constants for shift_reg_univ
package shift_reg_pkg;

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_SHL  = 3'b001;
    localparam logic [2:0] OP_SHR  = 3'b010;
    localparam logic [2:0] OP_ROTL = 3'b011;
    localparam logic [2:0] OP_ROTR = 3'b100;
    localparam logic [2:0] OP_LOAD = 3'b101;
    localparam logic [2:0] OP_ASR  = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_reg_core.sv
// rtl/shift_reg_core.sv - WIDTH-bit register with single-step next-value mux
module shift_reg_core
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       op,
    input  logic             s_in,
    input  logic [WIDTH-1:0] p_in,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_nxt;

    always_comb begin
        q_nxt = q;
        case (op)
            OP_HOLD: q_nxt = q;
            OP_SHL:  q_nxt = {q[WIDTH-2:0], s_in};
            OP_SHR:  q_nxt = {s_in, q[WIDTH-1:1]};
            OP_ROTL: q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
            OP_ROTR: q_nxt = {q[0], q[WIDTH-1:1]};
            OP_LOAD: q_nxt = p_in;
            OP_ASR:  q_nxt = {q[WIDTH-1], q[WIDTH-1:1]};
            OP_CLR:  q_nxt = '0;
            default: q_nxt = q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= q_nxt;
        end
    end

endmodule

// File: rtl/shift_reg_univ.sv
// rtl/shift_reg_univ.sv - universal shift register with single-step ops and burst shift engine
module shift_reg_univ
    import shift_reg_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       op,
    input  logic             s_in,
    input  logic [WIDTH-1:0] p_in,
    input  logic             start,
    input  logic             dir,
    input  logic [CNT_W-1:0] len,
    output logic [WIDTH-1:0] Q,
    output logic             s_out,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(WIDTH);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             dir_r, dir_nxt;
    logic [2:0]       core_op;

    shift_reg_core #(.WIDTH(WIDTH)) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .op    (core_op),
        .s_in  (s_in),
        .p_in  (p_in),
        .q     (Q)
    );

    // A burst is just a run of OP_SHL/OP_SHR steps; start wins over op in IDLE.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dir_nxt   = dir_r;
        core_op   = OP_HOLD;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        dir_nxt   = dir;
                        cnt_nxt   = (len > LEN_MAX) ? LEN_MAX : len;
                        state_nxt = ST_SHIFT;
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end else begin
                    core_op = op;
                end
            end
            ST_SHIFT: begin
                core_op = (dir_r == DIR_RIGHT) ? OP_SHR : OP_SHL;
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            dir_r <= DIR_LEFT;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            dir_r <= dir_nxt;
        end
    end

    assign busy  = (state == ST_SHIFT);
    assign done  = (state == ST_DONE);
    assign s_out = (dir_r == DIR_RIGHT) ? Q[0] : Q[WIDTH-1];

endmodule
